// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the DMem arbiter between the core load/store path and the host loader.
package dmem_arb_pkg;
   localparam int DEF_AW         = 8;
   localparam int DEF_DW         = 8;
   localparam int DEF_STARVE_MAX = 4;
   localparam int DEF_LOCK_MAX   = 64;

   typedef enum logic {ARB = 1'b0, HOST_LOCK = 1'b1} arb_state_t;
   typedef enum logic {OWN_CORE = 1'b0, OWN_HOST = 1'b1} arb_owner_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side handshake bundle (core or host) and the single-port DMem bus.
interface dmem_req_if
   import dmem_arb_pkg::*;
#(
   parameter int AW = DEF_AW,
   parameter int DW = DEF_DW
) ();
   logic          req;
   logic          wen;
   logic          lock;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdat;
   logic          gnt;
   logic          rvalid;
   logic [DW-1:0] rdat;

   modport master (output req, wen, lock, addr, wdat, input gnt, rvalid, rdat);
   modport slave  (input req, wen, lock, addr, wdat, output gnt, rvalid, rdat);
   // The core never locks the bus, so its arbiter-side view omits lock.
   modport core_slave (input req, wen, addr, wdat, output gnt, rvalid, rdat);
endinterface

interface dmem_bus_if
   import dmem_arb_pkg::*;
#(
   parameter int AW = DEF_AW,
   parameter int DW = DEF_DW
) ();
   logic          wen;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdat;
   logic [DW-1:0] rdat;

   modport master (output wen, addr, wdat, input rdat);
   modport slave  (input wen, addr, wdat, output rdat);
endinterface

// File: rtl/dmem_arbiter.sv
// Per-cycle DMem arbiter: core priority, bounded host starvation, host bus lock with a forced
// timeout, and registered read data with a one-cycle valid strobe per requester.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW         = DEF_AW,
   parameter int DW         = DEF_DW,
   parameter int STARVE_MAX = DEF_STARVE_MAX,
   parameter int LOCK_MAX   = DEF_LOCK_MAX
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   dmem_req_if.core_slave core,
   dmem_req_if.slave      host,
   dmem_bus_if.master     dm
);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam int LW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

   arb_state_t    r_state, w_state_next;
   arb_owner_t    w_owner;
   logic [SW-1:0] r_starve_cnt, w_starve_next;
   logic [LW-1:0] r_lock_cnt, w_lock_next;
   logic          r_lock_block, w_lock_block_next;
   logic          w_core_gnt, w_host_gnt, w_any_gnt;
   logic          w_starved, w_force_drop;
   logic [AW-1:0] r_dm_addr, w_dm_addr;
   logic [DW-1:0] r_dm_wdat, w_dm_wdat;
   logic          w_dm_wen;
   logic          r_core_rvalid, r_host_rvalid;
   logic [DW-1:0] r_core_rdat, r_host_rdat;

   always_comb begin
      w_core_gnt        = 1'b0;
      w_host_gnt        = 1'b0;
      w_state_next      = r_state;
      w_starved         = (r_starve_cnt == SW'(STARVE_MAX));
      w_force_drop      = (r_lock_cnt == LW'(LOCK_MAX - 1));
      w_lock_block_next = r_lock_block;

      // Grants are gated by reset so nothing reaches DMem while it is held.
      if (i_rst_n) begin
         case (r_state)
            ARB: begin
               if (core.req && !(w_starved && host.req)) begin
                  w_core_gnt = 1'b1;
               end else if (host.req) begin
                  w_host_gnt = 1'b1;
               end
               if (w_host_gnt && host.lock && !r_lock_block) begin
                  w_state_next = HOST_LOCK;
               end
            end
            HOST_LOCK: begin
               w_host_gnt = host.req;
               if (!host.lock || w_force_drop) begin
                  w_state_next = ARB;
               end
            end
            default: w_state_next = ARB;
         endcase
      end

      // After a forced drop the host must release lock once before it may relock.
      if (!host.lock) begin
         w_lock_block_next = 1'b0;
      end else if (r_state == HOST_LOCK && w_force_drop) begin
         w_lock_block_next = 1'b1;
      end

      if (host.req && !w_host_gnt) begin
         w_starve_next = w_starved ? r_starve_cnt : r_starve_cnt + SW'(1);
      end else begin
         w_starve_next = '0;
      end

      if (r_state == HOST_LOCK && w_state_next == HOST_LOCK) begin
         w_lock_next = r_lock_cnt + LW'(1);
      end else begin
         w_lock_next = '0;
      end
   end

   assign w_any_gnt = w_core_gnt | w_host_gnt;
   assign w_owner   = w_host_gnt ? OWN_HOST : OWN_CORE;

   always_comb begin
      w_dm_wen  = 1'b0;
      w_dm_addr = r_dm_addr;
      w_dm_wdat = r_dm_wdat;
      if (w_any_gnt) begin
         if (w_owner == OWN_HOST) begin
            w_dm_wen  = host.wen;
            w_dm_addr = host.addr;
            w_dm_wdat = host.wdat;
         end else begin
            w_dm_wen  = core.wen;
            w_dm_addr = core.addr;
            w_dm_wdat = core.wdat;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= ARB;
         r_starve_cnt  <= '0;
         r_lock_cnt    <= '0;
         r_lock_block  <= 1'b0;
         r_dm_addr     <= '0;
         r_dm_wdat     <= '0;
         r_core_rvalid <= 1'b0;
         r_host_rvalid <= 1'b0;
         r_core_rdat   <= '0;
         r_host_rdat   <= '0;
      end else begin
         r_state       <= w_state_next;
         r_starve_cnt  <= w_starve_next;
         r_lock_cnt    <= w_lock_next;
         r_lock_block  <= w_lock_block_next;
         r_dm_addr     <= w_dm_addr;
         r_dm_wdat     <= w_dm_wdat;
         r_core_rvalid <= w_core_gnt && !core.wen;
         r_host_rvalid <= w_host_gnt && !host.wen;
         if (w_core_gnt && !core.wen) begin
            r_core_rdat <= dm.rdat;
         end
         if (w_host_gnt && !host.wen) begin
            r_host_rdat <= dm.rdat;
         end
      end
   end

   assign core.gnt    = w_core_gnt;
   assign core.rvalid = r_core_rvalid;
   assign core.rdat   = r_core_rdat;
   assign host.gnt    = w_host_gnt;
   assign host.rvalid = r_host_rvalid;
   assign host.rdat   = r_host_rdat;
   assign dm.wen      = w_dm_wen;
   assign dm.addr     = w_dm_addr;
   assign dm.wdat     = w_dm_wdat;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: grant/bus checks inline, read data checked by a scoreboard monitor.
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;
   logic [7:0] last_addr = 8'h00;
   logic [7:0] core_q[$];
   logic [7:0] host_q[$];
   logic [7:0] mem [256];

   dmem_req_if #(.AW(8), .DW(8)) core_if ();
   dmem_req_if #(.AW(8), .DW(8)) host_if ();
   dmem_bus_if #(.AW(8), .DW(8)) dm_if ();

   dmem_arbiter #(.AW(8), .DW(8), .STARVE_MAX(4), .LOCK_MAX(64)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .core    (core_if),
      .host    (host_if),
      .dm      (dm_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port DMem model: combinational read, write at the edge.
   always @(posedge clk) begin
      if (dm_if.wen) mem[dm_if.addr] <= dm_if.wdat;
   end
   assign dm_if.rdat = mem[dm_if.addr];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic set_core(input logic req, input logic wen, input logic [7:0] addr, input logic [7:0] wdat);
      core_if.req  = req;
      core_if.wen  = wen;
      core_if.lock = 1'b0;
      core_if.addr = addr;
      core_if.wdat = wdat;
   endtask

   task automatic set_host(input logic req, input logic wen, input logic lock, input logic [7:0] addr,
                           input logic [7:0] wdat);
      host_if.req  = req;
      host_if.wen  = wen;
      host_if.lock = lock;
      host_if.addr = addr;
      host_if.wdat = wdat;
   endtask

   // One arbitration cycle: check grants and DMem bus, queue expected read data, advance.
   task automatic cyc(input string nm, input bit ec, input bit eh, input logic [7:0] cd, input logic [7:0] hd);
      logic ew;
      logic [7:0] ewd;
      @(negedge clk);
      chk($sformatf("%s.core_gnt", nm), 32'(core_if.gnt), 32'(ec));
      chk($sformatf("%s.host_gnt", nm), 32'(host_if.gnt), 32'(eh));
      ew  = ec ? core_if.wen : (eh ? host_if.wen : 1'b0);
      ewd = ec ? core_if.wdat : host_if.wdat;
      if (ec) last_addr = core_if.addr;
      else if (eh) last_addr = host_if.addr;
      chk($sformatf("%s.dm_wen", nm), 32'(dm_if.wen), 32'(ew));
      chk($sformatf("%s.dm_addr", nm), 32'(dm_if.addr), 32'(last_addr));
      if (ew) chk($sformatf("%s.dm_wdat", nm), 32'(dm_if.wdat), 32'(ewd));
      if (ec && !core_if.wen) core_q.push_back(cd);
      if (eh && !host_if.wen) host_q.push_back(hd);
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every rvalid pops and compares one expected read.
   always @(negedge clk) begin
      if (rst_n) begin
         if (core_if.rvalid) begin
            if (core_q.size() == 0) begin
               chk("core_rvalid_unexpected", 32'(core_if.rvalid), 32'd0);
            end else begin
               $display("core read data=0x%02h", core_if.rdat);
               chk("core_rdat", 32'(core_if.rdat), 32'(core_q.pop_front()));
            end
         end
         if (host_if.rvalid) begin
            if (host_q.size() == 0) begin
               chk("host_rvalid_unexpected", 32'(host_if.rvalid), 32'd0);
            end else begin
               $display("host read data=0x%02h", host_if.rdat);
               chk("host_rdat", 32'(host_if.rdat), 32'(host_q.pop_front()));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with both sides requesting: nothing granted, bus quiet.
      rst_n = 1'b0;
      set_core(1'b1, 1'b1, 8'h20, 8'h11);
      set_host(1'b1, 1'b1, 1'b0, 8'h30, 8'h22);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.core_gnt", 32'(core_if.gnt), 32'd0);
      chk("rst.host_gnt", 32'(host_if.gnt), 32'd0);
      chk("rst.core_rvalid", 32'(core_if.rvalid), 32'd0);
      chk("rst.host_rvalid", 32'(host_if.rvalid), 32'd0);
      chk("rst.dm_wen", 32'(dm_if.wen), 32'd0);
      chk("rst.dm_addr", 32'(dm_if.addr), 32'd0);
      chk("rst.dm_wdat", 32'(dm_if.wdat), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc("rel", 1, 0, 8'h00, 8'h00);
      set_host(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

      // Write then read-back, back-to-back reads, idle hold.
      set_core(1'b1, 1'b1, 8'h10, 8'h5A);
      cyc("t2_wr", 1, 0, 8'h00, 8'h00);
      set_core(1'b1, 1'b0, 8'h10, 8'h00);
      cyc("t2_rd10", 1, 0, 8'h5A, 8'h00);
      set_core(1'b1, 1'b0, 8'h20, 8'h00);
      cyc("t2_rd20", 1, 0, 8'h11, 8'h00);
      set_core(1'b0, 1'b0, 8'h77, 8'h00);
      cyc("t2_idle", 0, 0, 8'h00, 8'h00);
      @(negedge clk);
      chk("t2_hold.core_rvalid", 32'(core_if.rvalid), 32'd0);
      chk("t2_hold.core_rdat", 32'(core_if.rdat), 32'h11);
      @(posedge clk);
      #1;

      // Continuous contention: host wins every fifth cycle.
      set_core(1'b1, 1'b0, 8'h10, 8'h00);
      set_host(1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
      for (int i = 0; i < 10; i++) cyc($sformatf("t3_c%0d", i), (i % 5) != 4, (i % 5) == 4, 8'h5A, 8'h11);

      // Host lock burst with core starved out until lock drops.
      set_host(1'b1, 1'b0, 1'b1, 8'h20, 8'h00);
      for (int i = 0; i < 5; i++) cyc($sformatf("t4_arb%0d", i), i < 4, i == 4, 8'h5A, 8'h11);
      for (int k = 0; k < 8; k++) begin
         set_host(1'b1, 1'b1, 1'b1, 8'h40 + 8'(k), 8'h80 + 8'(k));
         cyc($sformatf("t4_lockwr%0d", k), 0, 1, 8'h00, 8'h00);
      end
      set_host(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      cyc("t4_drop", 0, 0, 8'h00, 8'h00);
      cyc("t4_after", 1, 0, 8'h5A, 8'h00);
      set_core(1'b0, 1'b0, 8'h00, 8'h00);
      set_host(1'b1, 1'b1, 1'b0, 8'h50, 8'hC3);
      cyc("t4_hwr50", 0, 1, 8'h00, 8'h00);
      set_host(1'b1, 1'b0, 1'b0, 8'h50, 8'h00);
      cyc("t4_hrd50", 0, 1, 8'h00, 8'hC3);
      set_host(1'b1, 1'b0, 1'b0, 8'h47, 8'h00);
      cyc("t4_hrd47", 0, 1, 8'h00, 8'h87);
      set_host(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      cyc("t4_idle", 0, 0, 8'h00, 8'h00);

      // Lock held too long: forced drop after 64 lock cycles, no relock while lock stays high.
      set_core(1'b1, 1'b0, 8'h10, 8'h00);
      set_host(1'b1, 1'b1, 1'b1, 8'h60, 8'h33);
      for (int i = 0; i < 5; i++) cyc($sformatf("t5_arb%0d", i), i < 4, i == 4, 8'h5A, 8'h00);
      for (int k = 0; k < 64; k++) cyc($sformatf("t5_lock%0d", k), 0, 1, 8'h00, 8'h00);
      for (int i = 0; i < 6; i++) cyc($sformatf("t5_post%0d", i), i != 4, i == 4, 8'h5A, 8'h00);
      set_host(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      cyc("t5_release", 1, 0, 8'h5A, 8'h00);
      set_core(1'b0, 1'b0, 8'h00, 8'h00);
      set_host(1'b1, 1'b1, 1'b1, 8'h61, 8'h44);
      cyc("t5_relock", 0, 1, 8'h00, 8'h00);
      set_core(1'b1, 1'b0, 8'h10, 8'h00);
      cyc("t5_locked", 0, 1, 8'h00, 8'h00);
      set_host(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      cyc("t5_unlock", 0, 0, 8'h00, 8'h00);
      cyc("t5_core", 1, 0, 8'h5A, 8'h00);
      set_core(1'b0, 1'b0, 8'h00, 8'h00);
      cyc("t5_idle", 0, 0, 8'h00, 8'h00);

      // Reset lands on a locked host read grant: access abandoned.
      set_host(1'b1, 1'b0, 1'b1, 8'h10, 8'h00);
      @(negedge clk);
      chk("t6.host_gnt", 32'(host_if.gnt), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst.host_gnt", 32'(host_if.gnt), 32'd0);
      @(posedge clk);
      #1;
      chk("t6.host_rvalid", 32'(host_if.rvalid), 32'd0);
      chk("t6.host_rdat", 32'(host_if.rdat), 32'd0);
      chk("t6.core_rdat", 32'(core_if.rdat), 32'd0);
      chk("t6.state", 32'(dut.r_state), 32'(ARB));
      last_addr = 8'h00;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      set_core(1'b1, 1'b0, 8'h20, 8'h00);
      cyc("t6_rel", 1, 0, 8'h11, 8'h00);
      set_core(1'b0, 1'b0, 8'h00, 8'h00);
      set_host(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      for (int i = 0; i < 3; i++) cyc($sformatf("drain%0d", i), 0, 0, 8'h00, 8'h00);
      chk("end.core_q_empty", 32'(core_q.size()), 32'd0);
      chk("end.host_q_empty", 32'(host_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
